sh2_sci_rx: RTL and testbench

//  Receive half of the on-chip SCI, asynchronous mode: samples RXD at 16x bit rate, deserialises

---
 rtl/sh2_sci_rx.sv | 262 ++++++++++++++++++++++++++
 tb/tb_sh2_sci_rx.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sh2_sci_rx.sv
// sh2_sci_rx: SCI receiver, asynchronous mode. 16x oversampling, 7/8 data bits, optional parity.
// Optional multiprocessor framing (MPB bit, MPIE filtering) is enabled by defining SCI_MP_EN.
module sh2_sci_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ce,
    input  logic       rxd,
    input  logic [7:0] smr,
    input  logic [7:0] brr,
    input  logic       re,
    input  logic       rie,
    input  logic       rdrf_clr,
    input  logic       orer_clr,
    input  logic       fer_clr,
    input  logic       per_clr,
    output logic [7:0] rdr,
    output logic       rdrf,
    output logic       orer,
    output logic       fer,
    output logic       per,
    output logic       rxi,
    output logic       eri,
    output logic       busy
`ifdef SCI_MP_EN
    ,
    input  logic       mpie,
    output logic       mpb,
    output logic       mpie_clr
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_EXTRA,
        S_STOP
    } state_t;

    state_t state, state_nxt;

    logic       chr, pe, oe;
    logic [1:0] cks;
    logic       extra_en, par_chk;

    assign chr = smr[6];
    assign pe  = smr[5];
    assign oe  = smr[4];
    assign cks = smr[1:0];

`ifdef SCI_MP_EN
    logic mp_mode;
    logic unused_smr;
    assign mp_mode    = smr[2];
    assign extra_en   = mp_mode | pe;
    assign par_chk    = pe & ~mp_mode;
    assign unused_smr = ^{smr[7], smr[3]};
`else
    logic unused_smr;
    assign extra_en   = pe;
    assign par_chk    = pe;
    assign unused_smr = ^{smr[7], smr[3], smr[2]};
`endif

    // ------------------------------------------------------------------
    // RXD synchroniser and falling-edge detect
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxd_s, rxd_prev, start_edge;

    // NOTE: sequential state is updated with non-blocking assignments only;
    // the synchroniser resets to all ones so reset release never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '1;
            rxd_prev <= 1'b1;
        end else if (ce) begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], rxd};
            rxd_prev <= rxd_s;
        end
    end

    assign rxd_s      = sync_q[SYNC_STAGES-1];
    assign start_edge = rxd_prev & ~rxd_s;

    // ------------------------------------------------------------------
    // Sample tick generator: free-running /4^(CKS+1) prescaler, then /(BRR+1)
    // ------------------------------------------------------------------
    logic [7:0] pre_cnt, pre_mask, brr_cnt;
    logic       pre_tick, brr_wrap, tick;

    always_comb begin
        case (cks)
            2'd0:    pre_mask = 8'h03;
            2'd1:    pre_mask = 8'h0F;
            2'd2:    pre_mask = 8'h3F;
            default: pre_mask = 8'hFF;
        endcase
    end

    assign pre_tick = (pre_cnt & pre_mask) == pre_mask;
    // >= rather than == so a BRR reduced below the running count wraps at once
    assign brr_wrap = brr_cnt >= brr;
    assign tick     = ce & pre_tick & brr_wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= 8'h00;
            brr_cnt <= 8'h00;
        end else if (ce) begin
            pre_cnt <= pre_cnt + 8'd1;
            if (pre_tick)
                brr_cnt <= brr_wrap ? 8'h00 : brr_cnt + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    logic [3:0] tick_cnt;
    logic [2:0] bit_cnt;
    logic       halt, last_bit;
    logic       sample, shift_en, extra_en_s, frame_end;

    assign halt     = orer | fer | per;
    assign last_bit = bit_cnt == (chr ? 3'd6 : 3'd7);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else if (ce)
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!re) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start_edge && !halt) state_nxt = S_START;
                S_START: if (sample) state_nxt = rxd_s ? S_IDLE : S_DATA;
                S_DATA:  if (sample && last_bit) state_nxt = extra_en ? S_EXTRA : S_STOP;
                S_EXTRA: if (sample) state_nxt = S_STOP;
                S_STOP:  if (sample) state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // NOTE: every always_comb output gets a default first, so no latch is inferred.
    always_comb begin
        busy       = 1'b0;
        sample     = 1'b0;
        shift_en   = 1'b0;
        extra_en_s = 1'b0;
        frame_end  = 1'b0;
        if (state != S_IDLE) begin
            busy   = 1'b1;
            sample = tick && (tick_cnt == 4'd7);
        end
        case (state)
            S_DATA:  shift_en   = sample;
            S_EXTRA: extra_en_s = sample;
            S_STOP:  frame_end  = sample & re;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Bit datapath
    // ------------------------------------------------------------------
    logic [7:0] data_q;
    logic       extra_q, stop_q, done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= 4'd0;
            bit_cnt  <= 3'd0;
            data_q   <= 8'h00;
            extra_q  <= 1'b0;
            stop_q   <= 1'b1;
            done_q   <= 1'b0;
        end else if (ce) begin
            if (state == S_IDLE)
                tick_cnt <= 4'd0;
            else if (tick)
                tick_cnt <= tick_cnt + 4'd1;

            if (state == S_START) begin
                bit_cnt <= 3'd0;
                data_q  <= 8'h00;
            end else if (shift_en) begin
                bit_cnt         <= bit_cnt + 3'd1;
                data_q[bit_cnt] <= rxd_s;
            end

            if (extra_en_s)
                extra_q <= rxd_s;
            if (frame_end)
                stop_q <= rxd_s;
            done_q <= frame_end;
        end
    end

    // ------------------------------------------------------------------
    // Completion: load RDR and update status flags one cycle after the stop sample
    // ------------------------------------------------------------------
    logic par_err, discard, take;
    logic rdr_load, rdrf_set, orer_set, fer_set, per_set;

    always_comb begin
        par_err = par_chk & (((^data_q) ^ extra_q) != oe);
`ifdef SCI_MP_EN
        discard = mp_mode & mpie & ~extra_q;
`else
        discard = 1'b0;
`endif
        take     = done_q & ~discard;
        orer_set = take & rdrf;
        rdr_load = take & ~rdrf;
        fer_set  = rdr_load & ~stop_q;
        per_set  = rdr_load & par_err;
        rdrf_set = rdr_load & stop_q & ~par_err;
    end

    // Set has priority over a coincident clear pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdr  <= 8'h00;
            rdrf <= 1'b0;
            orer <= 1'b0;
            fer  <= 1'b0;
            per  <= 1'b0;
        end else if (ce) begin
            if (rdr_load)
                rdr <= chr ? {1'b0, data_q[6:0]} : data_q;
            rdrf <= rdrf_set | (rdrf & ~rdrf_clr);
            orer <= orer_set | (orer & ~orer_clr);
            fer  <= fer_set  | (fer  & ~fer_clr);
            per  <= per_set  | (per  & ~per_clr);
        end
    end

    assign rxi = rdrf & rie;
    assign eri = halt & rie;

`ifdef SCI_MP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mpb <= 1'b0;
        else if (ce && done_q && mp_mode)
            mpb <= extra_q;
    end

    // done_q lasts exactly one enabled cycle, so this is a single-cycle pulse
    assign mpie_clr = ce & done_q & mp_mode & mpie & extra_q;
`endif

endmodule

// File: tb/tb_sh2_sci_rx.sv
// Testbench for sh2_sci_rx: directed framing cases plus randomized frames checked
// against a frame-level reference model of RDR and the SSR receive flags.
module tb_sh2_sci_rx;

    logic       clk = 1'b0;
    logic       rst_n, ce, rxd;
    logic [7:0] smr, brr;
    logic       re, rie, rdrf_clr, orer_clr, fer_clr, per_clr;
    logic [7:0] rdr;
    logic       rdrf, orer, fer, per, rxi, eri, busy;
`ifdef SCI_MP_EN
    logic       mpie, mpb, mpie_clr;
`endif

    sh2_sci_rx #(.SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ce       (ce),
        .rxd      (rxd),
        .smr      (smr),
        .brr      (brr),
        .re       (re),
        .rie      (rie),
        .rdrf_clr (rdrf_clr),
        .orer_clr (orer_clr),
        .fer_clr  (fer_clr),
        .per_clr  (per_clr),
        .rdr      (rdr),
        .rdrf     (rdrf),
        .orer     (orer),
        .fer      (fer),
        .per      (per),
        .rxi      (rxi),
        .eri      (eri),
        .busy     (busy)
`ifdef SCI_MP_EN
        ,
        .mpie     (mpie),
        .mpb      (mpb),
        .mpie_clr (mpie_clr)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int t_start = 0;
    int t_rdrf  = 0;
    logic rdrf_q = 1'b0;
    bit ce_rand  = 1'b0;
    bit swin_arm = 1'b0;

    // Reference model state
    logic [7:0] m_rdr;
    bit m_rdrf, m_orer, m_fer, m_per;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        rdrf_q <= rdrf;
        if (rdrf && !rdrf_q) t_rdrf <= cyc;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_rdr = 8'h00; m_rdrf = 0; m_orer = 0; m_fer = 0; m_per = 0;
    endtask

    // Frame-level rules: halted/disabled -> ignored; RDRF full -> overrun; else load and flag.
    task automatic model_frame(input logic [7:0] d, input bit par_bad, input bit stop_bad);
        logic [7:0] data;
        bit perr;
        if (!re || m_orer || m_fer || m_per) return;
        data = smr[6] ? {1'b0, d[6:0]} : d;
        perr = smr[5] && par_bad;
        if (m_rdrf) begin
            m_orer = 1;
        end else begin
            m_rdr = data;
            if (stop_bad) m_fer = 1;
            if (perr) m_per = 1;
            if (!stop_bad && !perr) m_rdrf = 1;
        end
    endtask

    task automatic step();
        @(negedge clk);
        ce = ce_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        if (swin_arm && rdrf) begin
            rdrf_clr = 1'b0;
            swin_arm = 1'b0;
        end
    endtask

    task automatic wait_ce(input int n);
        int k = 0;
        while (k < n) begin
            step();
            if (ce) k++;
        end
    endtask

    function automatic int bit_len();
        return 16 * (4 << (2 * int'(smr[1:0]))) * (int'(brr) + 1);
    endfunction

    task automatic send_frame(input logic [7:0] d, input bit par_bad, input bit stop_bad);
        int bl = bit_len();
        int nb = smr[6] ? 7 : 8;
        int ones;
        logic [7:0] dm;
        rxd = 1'b0;
        t_start = cyc;
        wait_ce(bl);
        for (int i = 0; i < nb; i++) begin
            rxd = d[i];
            wait_ce(bl);
        end
        if (smr[5]) begin
            dm   = smr[6] ? (d & 8'h7F) : d;
            ones = $countones(dm);
            rxd  = (smr[4] ? ~ones[0] : ones[0]) ^ par_bad;
            wait_ce(bl);
        end
        rxd = ~stop_bad;
        wait_ce(bl);
        rxd = 1'b1;
        wait_ce(bl / 4);
        model_frame(d, par_bad, stop_bad);
    endtask

    task automatic pulse_clr(input bit a, input bit b, input bit c, input bit d);
        @(negedge clk);
        ce = 1'b1;
        rdrf_clr = a; orer_clr = b; fer_clr = c; per_clr = d;
        @(negedge clk);
        rdrf_clr = 0; orer_clr = 0; fer_clr = 0; per_clr = 0;
        if (a) m_rdrf = 0;
        if (b) m_orer = 0;
        if (c) m_fer  = 0;
        if (d) m_per  = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, "_rdr"},  32'(rdr),  32'(m_rdr));
        check({tag, "_rdrf"}, 32'(rdrf), 32'(m_rdrf));
        check({tag, "_orer"}, 32'(orer), 32'(m_orer));
        check({tag, "_fer"},  32'(fer),  32'(m_fer));
        check({tag, "_per"},  32'(per),  32'(m_per));
        check({tag, "_rxi"},  32'(rxi),  32'(m_rdrf & rie));
        check({tag, "_eri"},  32'(eri),  32'((m_orer | m_fer | m_per) & rie));
        check({tag, "_busy"}, 32'(busy), 32'(0));
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [7:0] d;
        rst_n = 0; ce = 1; rxd = 1; smr = 8'h00; brr = 8'h00;
        re = 0; rie = 0; rdrf_clr = 0; orer_clr = 0; fer_clr = 0; per_clr = 0;
`ifdef SCI_MP_EN
        mpie = 0;
`endif
        model_reset();
        repeat (3) @(negedge clk);
        check_all("reset");
        rst_n = 1; re = 1; rie = 1;
        wait_ce(20);

        // 8N1 reception and latency from the start edge (9.5 bit times = 608 cycles)
        send_frame(8'h5A, 0, 0);
        check_all("t1");
        check("t1_rdr_5a", 32'(rdr), 32'h5A);
        lat = t_rdrf - t_start;
        check("t1_latency", 32'(lat >= 600 && lat <= 620), 32'(1));

        // Overrun, then halted reception until cleared
        send_frame(8'h33, 0, 0);
        check_all("t2_orer");
        send_frame(8'h11, 0, 0);
        check_all("t2_halted");
        pulse_clr(1, 1, 0, 0);
        check_all("t2_clr");

        // Framing error
        send_frame(8'hA5, 0, 1);
        check_all("t3_fer");
        pulse_clr(0, 0, 1, 0);

        // Odd parity: wrong then right
        smr = 8'h30;
        send_frame(8'h01, 1, 0);
        check_all("t4_per");
        pulse_clr(0, 0, 0, 1);
        send_frame(8'h01, 0, 0);
        check_all("t4_ok");
        pulse_clr(1, 0, 0, 0);

        // False start: 20-cycle low pulse
        smr = 8'h00;
        rxd = 0;
        wait_ce(10);
        check("t5_false_busy", 32'(busy), 32'(1));
        wait_ce(10);
        rxd = 1;
        wait_ce(80);
        check_all("t5_false");

        // 7-bit character
        smr = 8'h40;
        send_frame(8'hFF, 0, 0);
        check_all("t5_chr");
        check("t5_rdr_7f", 32'(rdr), 32'h7F);
        pulse_clr(1, 0, 0, 0);

        // Clear held across the completion cycle: set must win
        smr = 8'h00;
        rdrf_clr = 1; swin_arm = 1;
        send_frame(8'hC3, 0, 0);
        check_all("swin");
        check("swin_seen", 32'(swin_arm), 32'(0));
        rdrf_clr = 0; swin_arm = 0;

        // RE dropped mid-frame: frame discarded, state retained
        d = 8'h96;
        rxd = 0; wait_ce(bit_len());
        for (int i = 0; i < 3; i++) begin rxd = d[i]; wait_ce(bit_len()); end
        check("re_busy", 32'(busy), 32'(1));
        re = 0;
        wait_ce(2);
        check("re_drop_busy", 32'(busy), 32'(0));
        for (int i = 3; i < 8; i++) begin rxd = d[i]; wait_ce(bit_len()); end
        rxd = 1; wait_ce(bit_len());
        re = 1;
        wait_ce(bit_len() / 4);
        check_all("re_drop");

        // Asynchronous reset mid-data
        rxd = 0; wait_ce(bit_len());
        rxd = 1; wait_ce(bit_len());
        rxd = 0; wait_ce(bit_len() / 2);
        check("rst_busy", 32'(busy), 32'(1));
        rst_n = 0;
        #1;
        model_reset();
        check_all("rst_mid");
        rxd = 1;
        @(negedge clk);
        rst_n = 1;
        wait_ce(bit_len());
        check_all("post_rst");

        // Randomized frames; second half with a random clock enable
        for (int i = 0; i < 20; i++) begin
            bit cks1, par_bad, stop_bad;
            ce_rand  = (i >= 10);
            cks1     = ($urandom_range(0, 7) == 0);
            smr      = {1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                        1'($urandom), 1'b0, 1'b0, cks1};
            brr      = cks1 ? 8'd0 : 8'($urandom_range(0, 1));
            rie      = 1'($urandom);
            re       = ($urandom_range(0, 7) != 0);
            d        = 8'($urandom);
            par_bad  = ($urandom_range(0, 4) == 0);
            stop_bad = ($urandom_range(0, 5) == 0);
            send_frame(d, par_bad, stop_bad);
            check_all($sformatf("rnd%0d", i));
            re = 1;
            pulse_clr(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            check_all($sformatf("rnd%0d_clr", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
